mac_operand_feeder: RTL and testbench
=====================================

# mac_operand_feeder

Operand sequencer that drives one CNN-core MAC unit. On a command it clears the MAC and streams `len` operand pairs from two synchronous-read buffers (activations and weights) into the MAC. It waits out the MAC pipeline, captures the final accumulator and offers it on a valid/ready result port. It is the producer/consumer counterpart of the MAC: it generates `a`/`b`/`enable`/`rst` and samples `acc`.

## Interface
Parameters:
- `DATA_W`, 32: operand and accumulator width (signed).
- `ADDR_W`, 10: buffer address width.
- `MAC_LAT`, 3: clock edges from an operand pair at the MAC inputs to its contribution appearing on `mac_acc`.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `cmd_valid`  in  1: command offered.
- `cmd_ready`  out  1: high only in IDLE.
- `cmd_a_base`  in  ADDR_W: activation buffer start address.
- `cmd_b_base`  in  ADDR_W: weight buffer start address.
- `cmd_len`  in  ADDR_W+1: number of pairs, 0..2^ADDR_W.
- `a_rd_en`, `b_rd_en`  out  1: buffer read strobes.
- `a_rd_addr`, `b_rd_addr`  out  ADDR_W: read addresses.
- `a_rd_data`, `b_rd_data`  in  DATA_W: read data, valid the cycle after the strobe.
- `mac_a`, `mac_b`  out  DATA_W: MAC operands.
- `mac_en`  out  1: MAC enable.
- `mac_clr`  out  1: MAC synchronous reset.
- `mac_acc`  in  DATA_W: MAC accumulator.
- `res_valid`  out  1: result available.
- `res_ready`  in  1: result consumer ready.
- `res_data`  out  DATA_W: captured dot product.
- `busy`  out  1: state is not IDLE.

## Operation
- The FSM has five states:
  - IDLE: `cmd_ready`=1. On `cmd_valid`, it latches bases and len, clears the index, and goes to CLEAR.
  - CLEAR: one cycle with `mac_clr`=1. It goes to ISSUE if len≠0, else to DRAIN.
  - ISSUE: each cycle it asserts both strobes with addresses base+i (mod 2^ADDR_W) and increments i. After issuing i=len−1 it goes to DRAIN.
  - DRAIN: counts MAC_LAT+2 cycles, then captures `res_data`<=`mac_acc` and goes to RESULT.
  - RESULT: `res_valid`=1 and `res_data` is held stable. On `res_valid`&`res_ready` it goes to IDLE.
- The MAC holds its last product when enable is low, which would keep re-adding it. To prevent this:
  - `mac_en` is held at 1 in every non-reset cycle.
  - `mac_a`/`mac_b` carry the read data only on the cycle after a strobe (registered `pair_vld`). Otherwise they are 0.
- `mac_clr` = `rst` | (state==CLEAR).
- No arithmetic is performed in this block. Saturation is the MAC's concern.
- Reset values: state IDLE, `cmd_ready`=0 during reset, `res_valid`=0, `res_data`=0, strobes 0, addresses 0, `mac_a`/`mac_b`=0, `pair_vld`=0, `busy`=0.
- Reset mid-operation aborts the command. No result is produced and the MAC is cleared.
- A new command is not accepted in the cycle of the result handshake. IDLE is re-entered the following cycle.
- `cmd_len`=2^ADDR_W reads every address exactly once, with wrap-around.

## Timing
- Cycle 0: command handshake.
- Cycle 1: CLEAR.
- Cycles 2..len+1: strobes asserted.
- Cycles 3..len+2: operand pairs at the MAC.
- DRAIN occupies cycles len+2..len+6, and `res_data` is captured at the end of cycle len+6.
- `res_valid` rises in cycle len+7. Command-to-result latency is len+7 cycles, including len=0.
- ISSUE and DRAIN overlap in concept only. DRAIN begins the cycle after the last strobe, and the last operand pair is presented during the first DRAIN cycle.
- Throughput: one pair per cycle with no bubbles. Back-to-back commands are separated by at least 1 IDLE cycle after the handshake.

## Structure
- Shared package `mac_feed_pkg` holds:
  - the state enum (IDLE, CLEAR, ISSUE, DRAIN, RESULT);
  - default `MAC_LAT`=3;
  - the buffer read latency constant (1).
- Single module, no sub-module. The bench instantiates the real MAC unit plus two behavioural 1-cycle-latency RAM models.

## Test plan
- Directed scenarios:
  - len=4, A=[1,2,3,4], B=[5,6,7,8] -> `res_data`=70, `res_valid` in cycle 11, strobes exactly in cycles 2..5.
  - len=0 -> `res_data`=0 at cycle 7, no strobes asserted.
  - Negative operands: A=[−3,7], B=[4,−2] -> `res_data`=−26.
  - a_base=1022, len=4, ADDR_W=10 -> addresses 1022, 1023, 0, 1.
  - `res_ready` held low 10 cycles -> `res_valid` and `res_data` stable, `cmd_ready`=0, new `cmd_valid` ignored. The next command gives an independent correct sum, with no carry-over from the previous one.
  - `rst` in cycle 4 of a len=8 command -> all outputs at reset values the next cycle, no `res_valid`. A following len=2 command with A=[2,2], B=[3,3] gives 12.

Source files
------------

// File: rtl/mac_feed_pkg.sv
// Shared types and constants for the MAC operand feeder.
package mac_feed_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StIssue,
        StDrain,
        StResult
    } feed_state_e;

    localparam int unsigned MacLatDefault = 3;
    // Buffers return data the cycle after the read strobe.
    localparam int unsigned BufRdLat      = 1;

endpackage

// File: rtl/mac_operand_feeder.sv
// Sequences one dot product through a MAC: clear, stream operand pairs from two
// synchronous-read buffers, wait out the MAC pipeline, then hand off the result.
module mac_operand_feeder
    import mac_feed_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned MAC_LAT = MacLatDefault
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_a_base,
    input  logic [ADDR_W-1:0] cmd_b_base,
    input  logic [ADDR_W:0]   cmd_len,
    output logic              a_rd_en,
    output logic              b_rd_en,
    output logic [ADDR_W-1:0] a_rd_addr,
    output logic [ADDR_W-1:0] b_rd_addr,
    input  logic [DATA_W-1:0] a_rd_data,
    input  logic [DATA_W-1:0] b_rd_data,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic              mac_en,
    output logic              mac_clr,
    input  logic [DATA_W-1:0] mac_acc,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              busy
);

    // DRAIN starts when the last pair sits at the MAC inputs; MAC_LAT edges later it
    // is in the accumulator, and one extra cycle of slack covers the read latency.
    localparam int unsigned      DRAIN_CYCLES = MAC_LAT + BufRdLat + 1;
    localparam int unsigned      CNT_W        = $clog2(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [ADDR_W:0]  IDX_ONE      = {{ADDR_W{1'b0}}, 1'b1};

    feed_state_e       state_q, state_d;
    logic [ADDR_W-1:0] a_base_q, a_base_d;
    logic [ADDR_W-1:0] b_base_q, b_base_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              pair_vld_q;
    logic              issue;

    // Next-state logic: command latch, issue index, drain counter, result capture.
    always_comb begin
        state_d  = state_q;
        a_base_d = a_base_q;
        b_base_d = b_base_q;
        len_d    = len_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    a_base_d = cmd_a_base;
                    b_base_d = cmd_b_base;
                    len_d    = cmd_len;
                    idx_d    = '0;
                    state_d  = StClear;
                end
            end
            StClear: begin
                cnt_d   = '0;
                state_d = (len_q != '0) ? StIssue : StDrain;
            end
            StIssue: begin
                idx_d = idx_q + IDX_ONE;
                if ((idx_q + IDX_ONE) == len_q) begin
                    cnt_d   = '0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (cnt_q == CNT_LAST) begin
                    res_d   = mac_acc;
                    state_d = StResult;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            StResult: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset; reset aborts any command in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            a_base_q   <= '0;
            b_base_q   <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            res_q      <= '0;
            pair_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_base_q   <= a_base_d;
            b_base_q   <= b_base_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            res_q      <= res_d;
            pair_vld_q <= issue;
        end
    end

    // Outputs: operands are zeroed outside valid pairs so the always-enabled MAC
    // never re-accumulates stale data.
    always_comb begin
        issue     = (state_q == StIssue);
        cmd_ready = (state_q == StIdle) && !rst;
        a_rd_en   = issue;
        b_rd_en   = issue;
        a_rd_addr = issue ? (a_base_q + idx_q[ADDR_W-1:0]) : '0;
        b_rd_addr = issue ? (b_base_q + idx_q[ADDR_W-1:0]) : '0;
        mac_a     = pair_vld_q ? a_rd_data : '0;
        mac_b     = pair_vld_q ? b_rd_data : '0;
        mac_en    = !rst;
        mac_clr   = rst || (state_q == StClear);
        res_valid = (state_q == StResult);
        res_data  = res_q;
        busy      = (state_q != StIdle);
    end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Bench for mac_operand_feeder: behavioural MAC and 1-cycle RAMs around the DUT,
// dot products checked against a plain array-sum reference.
module tb_mac_operand_feeder;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned MAC_LAT = 3;
    localparam int          DEPTH   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_a_base;
    logic [ADDR_W-1:0] cmd_b_base;
    logic [ADDR_W:0]   cmd_len;
    logic              a_rd_en, b_rd_en;
    logic [ADDR_W-1:0] a_rd_addr, b_rd_addr;
    logic [DATA_W-1:0] a_rd_data, b_rd_data;
    logic [DATA_W-1:0] mac_a, mac_b;
    logic              mac_en, mac_clr;
    logic [DATA_W-1:0] mac_acc;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              busy;

    logic [DATA_W-1:0] a_mem [DEPTH];
    logic [DATA_W-1:0] b_mem [DEPTH];
    logic [DATA_W-1:0] p1, p2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mac_operand_feeder #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .MAC_LAT(MAC_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a_base(cmd_a_base),
        .cmd_b_base(cmd_b_base),
        .cmd_len   (cmd_len),
        .a_rd_en   (a_rd_en),
        .b_rd_en   (b_rd_en),
        .a_rd_addr (a_rd_addr),
        .b_rd_addr (b_rd_addr),
        .a_rd_data (a_rd_data),
        .b_rd_data (b_rd_data),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_en    (mac_en),
        .mac_clr   (mac_clr),
        .mac_acc   (mac_acc),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    // Synchronous-read buffers: data appears the cycle after the strobe, else held.
    always_ff @(posedge clk) begin
        if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
        if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];
    end

    // MAC model, 3-edge latency; with enable low it keeps re-adding its held product.
    always_ff @(posedge clk) begin
        if (mac_clr) begin
            p1      <= '0;
            p2      <= '0;
            mac_acc <= '0;
        end else if (mac_en) begin
            p1      <= mac_a * mac_b;
            p2      <= p1;
            mac_acc <= mac_acc + p2;
        end else begin
            mac_acc <= mac_acc + p2;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic int ref_dot(input int ab, input int bb, input int len);
        int s = 0;
        for (int i = 0; i < len; i++) begin
            s += int'(a_mem[(ab + i) % DEPTH]) * int'(b_mem[(bb + i) % DEPTH]);
        end
        return s;
    endfunction

    // One full command: checks strobe timing/addresses, result timing/value, handshake.
    // hold > 0 keeps res_ready low that many cycles while offering a competing command.
    task automatic run_cmd(input int ab, input int bb, input int len, input int hold,
                           input string tag);
        int exp_sum;
        int bad_strobe = 0;
        int bad_addr   = 0;
        int early      = 0;
        int unstable   = 0;
        int waited     = 0;
        logic exp_s;
        while (!cmd_ready && waited < 40) begin
            tick();
            waited++;
        end
        check({tag, "_cmd_ready_wait"}, 32'(cmd_ready), 32'd1);
        exp_sum    = ref_dot(ab, bb, len);
        cmd_a_base = ADDR_W'(ab);
        cmd_b_base = ADDR_W'(bb);
        cmd_len    = (ADDR_W + 1)'(len);
        cmd_valid  = 1'b1;
        res_ready  = (hold == 0);
        for (int k = 1; k <= len + 7; k++) begin
            tick();
            if (k == 1) begin
                cmd_valid = 1'b0;
                check({tag, "_clear"}, 32'(mac_clr), 32'd1);
            end
            exp_s = (k >= 2) && (k <= len + 1);
            if (a_rd_en !== exp_s || b_rd_en !== exp_s) bad_strobe++;
            if (exp_s && (int'(a_rd_addr) != (ab + k - 2) % DEPTH ||
                          int'(b_rd_addr) != (bb + k - 2) % DEPTH)) bad_addr++;
            if (k < len + 7 && res_valid !== 1'b0) early++;
        end
        check({tag, "_strobes"}, 32'(bad_strobe), 32'd0);
        check({tag, "_addrs"}, 32'(bad_addr), 32'd0);
        check({tag, "_no_early_valid"}, 32'(early), 32'd0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd1);
        check({tag, "_res_data"}, res_data, 32'(exp_sum));
        check({tag, "_cmd_ready_in_result"}, 32'(cmd_ready), 32'd0);
        if (hold > 0) begin
            cmd_a_base = ADDR_W'($urandom);
            cmd_len    = (ADDR_W + 1)'(3);
            cmd_valid  = 1'b1;
            for (int h = 1; h < hold; h++) begin
                tick();
                if (res_valid !== 1'b1 || res_data !== 32'(exp_sum) || cmd_ready !== 1'b0 ||
                    a_rd_en !== 1'b0) unstable++;
            end
            check({tag, "_hold_stable"}, 32'(unstable), 32'd0);
            res_ready = 1'b1;
        end
        tick();
        // cmd_valid may still be high here: it must not have been taken at the handshake.
        check({tag, "_idle_after"}, {30'd0, busy, res_valid}, 32'd0);
        check({tag, "_cmd_ready_after"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int bad;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_a_base = '0;
        cmd_b_base = '0;
        cmd_len    = '0;
        res_ready  = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            a_mem[i] = $urandom;
            b_mem[i] = $urandom;
        end

        // Reset behaviour.
        tick();
        tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_mac_clr", 32'(mac_clr), 32'd1);
        check("rst_mac_en", 32'(mac_en), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_strobes_addrs", {a_rd_en, b_rd_en, a_rd_addr, b_rd_addr}, 32'd0);
        check("rst_operands", mac_a | mac_b, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_mac_en", 32'(mac_en), 32'd1);

        // len=4, A=[1,2,3,4], B=[5,6,7,8] -> 70.
        for (int i = 0; i < 4; i++) begin
            a_mem[10 + i]  = 32'(i + 1);
            b_mem[100 + i] = 32'(i + 5);
        end
        check("ref_dot_70", 32'(ref_dot(10, 100, 4)), 32'd70);
        run_cmd(10, 100, 4, 0, "len4");

        // len=0 -> 0, no strobes.
        run_cmd(500, 600, 0, 0, "len0");

        // Negative operands -> -26.
        a_mem[400] = -32'sd3;
        a_mem[401] = 32'sd7;
        b_mem[700] = 32'sd4;
        b_mem[701] = -32'sd2;
        run_cmd(400, 700, 2, 0, "neg");
        check("neg_value", res_data, -32'sd26);

        // Address wrap-around.
        run_cmd(1022, 1021, 4, 0, "wrap");

        // Back-pressure on the result port, then an independent command.
        run_cmd(50, 60, 5, 10, "hold");
        run_cmd(70, 80, 3, 0, "after_hold");

        // Reset in cycle 4 of a len=8 command.
        cmd_a_base = ADDR_W'(20);
        cmd_b_base = ADDR_W'(30);
        cmd_len    = (ADDR_W + 1)'(8);
        cmd_valid  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            cmd_valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("abort_mac_clr", 32'(mac_clr), 32'd1);
        tick();
        rst = 1'b0;
        #1;
        check("abort_strobes_addrs", {a_rd_en, b_rd_en, a_rd_addr, b_rd_addr}, 32'd0);
        check("abort_outputs", {29'd0, res_valid, busy, mac_clr}, 32'd0);
        check("abort_res_data", res_data, 32'd0);
        check("abort_operands", mac_a | mac_b, 32'd0);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (res_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("abort_no_result", 32'(bad), 32'd0);
        a_mem[200] = 32'd2;
        a_mem[201] = 32'd2;
        b_mem[300] = 32'd3;
        b_mem[301] = 32'd3;
        run_cmd(200, 300, 2, 0, "post_abort");
        check("post_abort_value", res_data, 32'd12);

        // Randomized commands.
        for (int r = 0; r < 8; r++) begin
            run_cmd(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
                    int'($urandom_range(0, 24)), (r == 3) ? 4 : 0, "rand");
        end

        // Full buffer: every address once, wrapping from a non-zero base.
        run_cmd(int'($urandom_range(1, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
                DEPTH, 0, "full");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
